// File: rtl/spike_pushback_collector.sv
// spike_pushback_collector: buffers pushed-back spikes in a FIFO, counts class-neuron spikes, argmax on inference done
module spike_pushback_collector #(
  parameter int M          = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int N_CLASS    = 10,
  parameter int CLASS_BASE = 246,
  parameter int CNT_W      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          spike_pushback_i,
  input  logic [M-1:0]                  spike_pushback_addr_i,
  input  logic                          inference_done_i,
  input  logic                          clear_i,
  output logic                          rd_valid_o,
  input  logic                          rd_ready_i,
  output logic [M-1:0]                  rd_addr_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o,
  output logic [N_CLASS*CNT_W-1:0]      class_cnt_o,
  output logic [$clog2(N_CLASS)-1:0]    winner_o,
  output logic                          winner_valid_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(N_CLASS);
  typedef enum logic [1:0] {COLLECT, ARGMAX, DONE} state_t;
  state_t state_q, state_d;
  logic [M-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [CNT_W-1:0] cls_q [N_CLASS];
  logic [CNT_W-1:0] cls_d [N_CLASS];
  logic [CW-1:0] scan_q, scan_d, best_q, best_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic full, pop, push, drop, hit;
  logic [M:0] off;
  always_comb begin
    full = cnt_q == (AW+1)'(FIFO_DEPTH);
    pop = cnt_q != '0 && rd_ready_i;
    push = spike_pushback_i && (!full || pop);
    drop = spike_pushback_i && full && !pop;
    // one extra bit so indices below CLASS_BASE wrap to large offsets
    off = {1'b0, spike_pushback_addr_i} - (M+1)'(CLASS_BASE);
    hit = spike_pushback_i && state_q == COLLECT && off < (M+1)'(N_CLASS);
    wr_d = clear_i ? '0 : wr_q + AW'(push);
    rd_d = clear_i ? '0 : rd_q + AW'(pop);
    cnt_d = clear_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = !clear_i && (ovf_q || drop);
    for (int k = 0; k < N_CLASS; k++)
      cls_d[k] = clear_i ? '0 : cls_q[k] + CNT_W'(hit && off == (M+1)'(k) && cls_q[k] != '1);
    state_d = state_q;
    scan_d = scan_q;
    best_d = best_q;
    best_cnt_d = best_cnt_q;
    if (clear_i) begin
      state_d = COLLECT;
      scan_d = '0;
      best_d = '0;
      best_cnt_d = '0;
    end else if (state_q == COLLECT && inference_done_i) begin
      state_d = ARGMAX;
      scan_d = '0;
      best_d = '0;
      best_cnt_d = '0;
    end else if (state_q == ARGMAX) begin
      if (cls_q[scan_q] > best_cnt_q) begin
        best_d = scan_q;
        best_cnt_d = cls_q[scan_q];
      end
      scan_d = scan_q + 1'b1;
      state_d = scan_q == CW'(N_CLASS-1) ? DONE : ARGMAX;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      scan_q <= '0;
      best_q <= '0;
      best_cnt_q <= '0;
      for (int k = 0; k < N_CLASS; k++) cls_q[k] <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      scan_q <= scan_d;
      best_q <= best_d;
      best_cnt_q <= best_cnt_d;
      for (int k = 0; k < N_CLASS; k++) cls_q[k] <= cls_d[k];
    end
  end
  always_ff @(posedge clk_i) if (push) mem_q[wr_q] <= spike_pushback_addr_i;
  assign rd_valid_o = cnt_q != '0;
  assign rd_addr_o = rd_valid_o ? mem_q[rd_q] : '0;
  assign fifo_count_o = cnt_q;
  assign overflow_o = ovf_q;
  assign winner_valid_o = state_q == DONE;
  assign winner_o = winner_valid_o ? best_q : '0;
  for (genvar g = 0; g < N_CLASS; g++) begin : g_cnt
    assign class_cnt_o[g*CNT_W +: CNT_W] = cls_q[g];
  end
endmodule

// File: tb/tb_spike_pushback_collector.sv
// tb_spike_pushback_collector: directed stimulus checked every cycle against a queue/array model
module tb_spike_pushback_collector;
  logic clk = 0, rst_n = 0;
  logic sp = 0, dn = 0, cl = 0, rdy = 0;
  logic [7:0] ad = 0;
  logic rd_valid, overflow, winner_valid;
  logic [7:0] rd_addr;
  logic [4:0] fifo_count;
  logic [79:0] class_cnt;
  logic [3:0] winner;
  int errors = 0, checks = 0;
  int mq[$];
  int mcnt[10];
  bit movf;
  int mst, mtimer, mwin;
  spike_pushback_collector dut (
    .clk_i(clk), .rst_ni(rst_n), .spike_pushback_i(sp), .spike_pushback_addr_i(ad),
    .inference_done_i(dn), .clear_i(cl), .rd_valid_o(rd_valid), .rd_ready_i(rdy),
    .rd_addr_o(rd_addr), .fifo_count_o(fifo_count), .overflow_o(overflow),
    .class_cnt_o(class_cnt), .winner_o(winner), .winner_valid_o(winner_valid));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int dcnt(input int k);
    logic [79:0] v;
    v = class_cnt;
    return int'(v[k*8 +: 8]);
  endfunction
  task automatic model_reset();
    mq.delete();
    foreach (mcnt[k]) mcnt[k] = 0;
    movf = 0; mst = 0; mtimer = 0; mwin = 0;
  endtask
  // mst: 0 collecting, 1 scanning (mtimer cycles left), 2 done
  task automatic model_step();
    bit pop;
    pop = mq.size() > 0 && rdy;
    if (cl) begin
      model_reset();
      return;
    end
    if (pop) void'(mq.pop_front());
    if (sp) begin
      if (mq.size() < 16) mq.push_back(int'(ad));
      else movf = 1;
    end
    if (mst == 0 && sp && ad >= 246 && mcnt[ad-246] < 255) mcnt[ad-246]++;
    if (mst == 0 && dn) begin
      mst = 1; mtimer = 10; mwin = 0;
      for (int k = 1; k < 10; k++) if (mcnt[k] > mcnt[mwin]) mwin = k;
    end else if (mst == 1) begin
      mtimer--;
      if (mtimer == 0) mst = 2;
    end
  endtask
  always @(negedge clk) begin
    chk("rd_valid", rd_valid, mq.size() != 0);
    chk("rd_addr", rd_addr, mq.size() != 0 ? mq[0] : 0);
    chk("fifo_count", fifo_count, mq.size());
    chk("overflow", overflow, movf);
    for (int k = 0; k < 10; k++) chk($sformatf("class_cnt[%0d]", k), dcnt(k), mcnt[k]);
    chk("winner_valid", winner_valid, mst == 2);
    chk("winner", winner, mst == 2 ? mwin : 0);
  end
  task automatic cyc(input logic s, input logic [7:0] a, input logic d, input logic c, input logic r);
    sp = s; ad = a; dn = d; cl = c; rdy = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("reset_count", fifo_count, 0);
    chk("reset_winner_valid", winner_valid, 0);
    // 1: order and class counting
    cyc(1, 3, 0, 0, 0); cyc(1, 250, 0, 0, 0); cyc(1, 250, 0, 0, 0); cyc(1, 255, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_count", fifo_count, 4);
    chk("t1_head", rd_addr, 3);
    repeat (5) cyc(0, 0, 0, 0, 1);
    chk("t1_cnt4", dcnt(4), 2);
    chk("t1_empty", rd_valid, 0);
    // 2: overflow, then push+pop while full
    for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0, 0, 0);
    chk("t2_count", fifo_count, 16);
    chk("t2_ovf", overflow, 1);
    cyc(1, 99, 0, 0, 1);
    chk("t2_count_pp", fifo_count, 16);
    chk("t2_head_pp", rd_addr, 1);
    chk("t2_ovf_pp", overflow, 1);
    cyc(0, 0, 0, 1, 0);
    chk("t2_clear_ovf", overflow, 0);
    // 3: tie between class 2 and 7
    for (int i = 0; i < 5; i++) cyc(1, 248, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 253, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 255, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1);
    chk("t3_valid_early", winner_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t3_valid", winner_valid, 1);
    chk("t3_winner", winner, 2);
    // 4b: spikes in DONE fill FIFO only
    for (int i = 0; i < 3; i++) cyc(1, 248, 1, 0, 0);
    chk("t4_done_cnt2", dcnt(2), 5);
    chk("t4_done_fifo", fifo_count, 3);
    chk("t4_done_winner", winner, 2);
    // 5: clear in DONE with simultaneous spike
    cyc(1, 247, 0, 1, 0);
    chk("t5_fifo", fifo_count, 0);
    chk("t5_cnt2", dcnt(2), 0);
    chk("t5_valid", winner_valid, 0);
    // 4: saturation
    for (int i = 0; i < 300; i++) cyc(1, 246, 0, 0, 1);
    chk("t4_sat", dcnt(0), 255);
    // 6: async reset mid-ARGMAX
    for (int i = 0; i < 3; i++) cyc(1, 250, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("t6_valid", rd_valid, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_cnt0", dcnt(0), 0);
    chk("t6_cnt4", dcnt(4), 0);
    @(negedge clk);
    rst_n = 1;
    cyc(1, 247, 0, 0, 0); cyc(1, 247, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    repeat (10) cyc(0, 0, 0, 0, 1);
    chk("t6_winner_valid", winner_valid, 1);
    chk("t6_winner", winner, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
